// File: rtl/buffer_route_scheduler.sv
// Buffer RAM write-ownership arbiter and registered read-select router.
// Optional perf counters are built when BUFFER_ROUTE_SCHED_PERF_EN is defined.
module buffer_route_scheduler #(
    parameter int SLOT_NUM   = 20,
    parameter int MODULE_NUM = 20,
    parameter int LEN_W      = 16,
    parameter int ROUTE_LAT  = 2
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [MODULE_NUM-1:0]                  wr_req,
    input  logic [MODULE_NUM*$clog2(SLOT_NUM)-1:0] wr_slot,
    input  logic [MODULE_NUM*LEN_W-1:0]            wr_len,
    output logic [MODULE_NUM-1:0]                  wr_gnt,
    output logic [MODULE_NUM-1:0]                  wr_err,
    input  logic [MODULE_NUM-1:0]                  rd_en,
    input  logic [MODULE_NUM*$clog2(SLOT_NUM)-1:0] rd_slot,
    output logic [SLOT_NUM*$clog2(MODULE_NUM)-1:0] module_select,
    output logic [MODULE_NUM*$clog2(SLOT_NUM)-1:0] slot_select,
    output logic [SLOT_NUM-1:0]                    slot_busy
`ifdef BUFFER_ROUTE_SCHED_PERF_EN
    ,
    output logic [31:0]                            grant_cnt,
    output logic [31:0]                            stall_cnt
`endif
);
    localparam int SW = $clog2(SLOT_NUM);
    localparam int MW = $clog2(MODULE_NUM);
    localparam int CW = LEN_W + 2;
    localparam logic [SW-1:0] SLOT_PARK = SW'(SLOT_NUM);
    localparam logic [MW-1:0] MOD_PARK  = MW'(MODULE_NUM);

    typedef enum logic {IDLE, HOLD} slot_state_t;

    slot_state_t   state_q [SLOT_NUM];
    logic [CW-1:0] cnt_q   [SLOT_NUM];
    logic [MW-1:0] ptr_q   [SLOT_NUM];
    logic [MW-1:0] owner_q [SLOT_NUM];

    logic [SW-1:0]         req_slot [MODULE_NUM];
    logic [LEN_W-1:0]      req_len  [MODULE_NUM];
    logic [MODULE_NUM-1:0] bad;
    logic [MODULE_NUM-1:0] owns;
    logic [MODULE_NUM-1:0] valid;
    logic [MODULE_NUM-1:0] gnt_now;
    logic [SLOT_NUM-1:0]   win_vld;
    logic [MW-1:0]         win_idx [SLOT_NUM];

    function automatic int wrap_mod(input int a);
        return (a >= MODULE_NUM) ? a - MODULE_NUM : a;
    endfunction

    always_comb begin
        for (int m = 0; m < MODULE_NUM; m++) begin
            req_slot[m] = wr_slot[m*SW +: SW];
            req_len[m]  = wr_len[m*LEN_W +: LEN_W];
        end
    end

    always_comb begin
        for (int m = 0; m < MODULE_NUM; m++)
            bad[m] = wr_req[m] &&
                     (req_slot[m] >= SLOT_PARK || req_len[m] == '0);
    end

    // a module that already owns a slot stays out of arbitration
    always_comb begin
        owns = '0;
        for (int s = 0; s < SLOT_NUM; s++)
            for (int m = 0; m < MODULE_NUM; m++)
                if (state_q[s] == HOLD && owner_q[s] == MW'(m))
                    owns[m] = 1'b1;
    end

    assign valid = wr_req & ~bad & ~owns;

    // a slot may regrant on the last drain cycle so the next owner lands
    // exactly when the previous hold window closes
    always_comb begin
        gnt_now = '0;
        for (int s = 0; s < SLOT_NUM; s++) begin
            win_vld[s] = 1'b0;
            win_idx[s] = '0;
            for (int k = 0; k < MODULE_NUM; k++) begin
                if ((state_q[s] == IDLE || cnt_q[s] == '0) && !win_vld[s]
                    && valid[wrap_mod(int'(ptr_q[s]) + k)]
                    && req_slot[wrap_mod(int'(ptr_q[s]) + k)] == SW'(s)) begin
                    win_vld[s] = 1'b1;
                    win_idx[s] = MW'(wrap_mod(int'(ptr_q[s]) + k));
                end
            end
            for (int m = 0; m < MODULE_NUM; m++)
                if (win_vld[s] && win_idx[s] == MW'(m))
                    gnt_now[m] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                state_q[s] <= IDLE;
                cnt_q[s]   <= '0;
                ptr_q[s]   <= '0;
                owner_q[s] <= '0;
            end
            module_select <= {SLOT_NUM{MOD_PARK}};
            slot_busy     <= '0;
        end else begin
            for (int s = 0; s < SLOT_NUM; s++) begin
                if (win_vld[s]) begin
                    state_q[s] <= HOLD;
                    owner_q[s] <= win_idx[s];
                    cnt_q[s]   <= CW'(req_len[win_idx[s]]) + CW'(ROUTE_LAT);
                    ptr_q[s]   <= (win_idx[s] == MW'(MODULE_NUM - 1)) ?
                                  '0 : win_idx[s] + 1'b1;
                    module_select[s*MW +: MW] <= win_idx[s];
                    slot_busy[s] <= 1'b1;
                end else if (state_q[s] == HOLD) begin
                    if (cnt_q[s] != '0) begin
                        cnt_q[s] <= cnt_q[s] - 1'b1;
                    end else begin
                        state_q[s] <= IDLE;
                        module_select[s*MW +: MW] <= MOD_PARK;
                        slot_busy[s] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_gnt      <= '0;
            wr_err      <= '0;
            slot_select <= {MODULE_NUM{SLOT_PARK}};
        end else begin
            wr_gnt <= gnt_now;
            wr_err <= bad;
            for (int m = 0; m < MODULE_NUM; m++)
                slot_select[m*SW +: SW] <=
                    (rd_en[m] && rd_slot[m*SW +: SW] < SLOT_PARK) ?
                    rd_slot[m*SW +: SW] : SLOT_PARK;
        end
    end

`ifdef BUFFER_ROUTE_SCHED_PERF_EN
    logic [32:0] grant_sum;
    logic [32:0] stall_sum;

    always_comb begin
        grant_sum = {1'b0, grant_cnt} + 33'($countones(gnt_now));
        stall_sum = {1'b0, stall_cnt} + 33'(|(wr_req & ~bad & ~gnt_now));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            grant_cnt <= grant_sum[32] ? '1 : grant_sum[31:0];
            stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
        end
    end
`else
    // no perf counters in this build
`endif

endmodule
